toggle_counter: RTL and testbench
=================================

TOGGLE_COUNTER -- requirements
Module: toggle_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter/register width in bits (legal range 2..32).
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, terminal value for counting modes (legal range 1..2**WIDTH-1).
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-low reset.
REQ-005 Port en  in  1  count/toggle enable; 0 = hold all state except on load.
REQ-006 Port mode  in  2  00 raw toggle, 01 count up, 10 count down, 11 hold.
REQ-007 Port sat  in  1  1 = saturate at bounds, 0 = wrap at bounds.
REQ-008 Port t  in  WIDTH  per-bit toggle mask; used in raw mode only.
REQ-009 Port load  in  1  synchronous parallel load strobe.
REQ-010 Port din  in  WIDTH  parallel load value.
REQ-011 Port q  out  WIDTH  registered counter/register value.
REQ-012 Port tc  out  1  registered terminal-count pulse.
REQ-013 Port ovf  out  1  registered sticky bound-crossing flag.

Function
REQ-014 Edge priority SHALL be: rst, then load, then en=0 (hold), then mode.
REQ-015 Load SHALL set q to din, or to MAX_VAL if din > MAX_VAL, and SHALL clear ovf and tc regardless of en or mode.
REQ-016 Raw mode with en=1 SHALL set q to q XOR t per bit, SHALL ignore MAX_VAL and sat, and SHALL drive tc=0.
REQ-017 Up mode with en=1 and q < MAX_VAL SHALL set q to q+1.
REQ-018 Up mode with en=1 and q >= MAX_VAL SHALL set q to 0 if sat=0, or to MAX_VAL if sat=1.
REQ-019 Down mode with en=1 and q > 0 SHALL set q to q-1, or to MAX_VAL if q > MAX_VAL.
REQ-020 Down mode with en=1 and q=0 SHALL set q to MAX_VAL if sat=0, or hold 0 if sat=1.
REQ-021 Hold mode, or en=0 without load, SHALL keep q, ovf unchanged and SHALL drive tc=0.
REQ-022 tc SHALL be 1 for exactly the cycle after an edge on which REQ-018 or REQ-020 applied (wrap or saturation hit), and 0 otherwise.
REQ-023 ovf SHALL set on the same edge tc is set, and SHALL stay 1 until the next load or reset.
REQ-024 In saturate mode, repeated enabled edges at the bound SHALL re-assert tc each cycle.
REQ-025 Every bit of q SHALL be held in a toggle cell; the next value SHALL be realised as the toggle vector q XOR q_next.
REQ-026 Mode or sat changes SHALL take effect on the very next edge with no pipeline latency.

Reset
REQ-027 rst=0 SHALL immediately, without a clock, force q=0, tc=0 and ovf=0.
REQ-028 Deassertion of rst SHALL take effect at the first rising clk edge after rst returns to 1; no update occurs while rst=0.
REQ-029 Reset asserted mid-count SHALL discard all in-flight state; no tc is emitted for the interrupted count.

Structure
REQ-030 A shared package toggle_counter_pkg SHALL hold the mode encodings MODE_RAW, MODE_UP, MODE_DOWN and MODE_HOLD as a 2-bit typedef.
REQ-031 A single sub-module t_ff_cell SHALL be instantiated WIDTH times; it is a one-bit toggle cell with async active-low reset and a toggle-enable input.
REQ-032 The next-value, clamp and terminal-detect logic SHALL reside in toggle_counter only.

Verification
REQ-033 Scenario: WIDTH=4, MAX_VAL=9, up, sat=0, en=1 for 12 edges from 0 -> q sequence 1..9,0,1,2, with tc high exactly one cycle after the 9->0 edge, and ovf=1.
REQ-034 Scenario: WIDTH=4, MAX_VAL=9, down, sat=1, from load din=2 -> q 1,0,0,0, with tc high on each cycle after an edge at 0, and ovf=1.
REQ-035 Scenario: raw mode, WIDTH=8, q=8'h00, t=8'hA5 for 2 edges -> q=8'hA5 then 8'h00, with tc=0 throughout.
REQ-036 Scenario: load din=15 with WIDTH=4, MAX_VAL=9 -> q=9 and ovf cleared; load with en=0 is still accepted.
REQ-037 Scenario: rst pulled low between clock edges mid-count at q=5 -> q=0, tc=0 and ovf=0 immediately; with rst back high, the first edge increments from 0.
REQ-038 Scenario: en=0 or mode=hold for 5 edges at q=7 -> q stays 7 and tc=0; load and mode-up on the same edge -> the load wins.

Source files
------------

// File: rtl/toggle_counter_pkg.sv
// Shared types for the toggle counter slice.
// Holds the 2-bit operating mode encoding.
package toggle_counter_pkg;

  typedef enum logic [1:0] {
    MODE_RAW  = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

endpackage

// File: rtl/toggle_counter_t_ff_cell.sv
// One-bit toggle flip-flop with async active-low reset.
// Flips its stored bit on every edge where tog_i is set.
module t_ff_cell (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tog_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= 1'b0;
    end else if (tog_i) begin
      q_q <= ~q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/toggle_counter.sv
// Up/down/raw-toggle counter built from T flip-flops.
// Next value is computed here and applied as a toggle vector.
module toggle_counter
  import toggle_counter_pkg::*;
#(
  parameter int unsigned        WIDTH   = 8,
  parameter logic [WIDTH-1:0]   MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  mode_e            mode_s;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] tog;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  assign mode_s = mode_e'(mode);

  always_comb begin
    cnt_d = cnt;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    unique case (1'b1)
      load: begin
        cnt_d = (din > MAX_VAL) ? MAX_VAL : din;
        ovf_d = 1'b0;
      end
      !load && !en: begin
        cnt_d = cnt;
      end
      !load && en: begin
        unique case (mode_s)
          MODE_RAW: begin
            cnt_d = cnt ^ t;
          end
          MODE_UP: begin
            if (cnt < MAX_VAL) begin
              cnt_d = cnt + ONE;
            end else begin
              cnt_d = sat ? MAX_VAL : ZERO;
              tc_d  = 1'b1;
              ovf_d = 1'b1;
            end
          end
          MODE_DOWN: begin
            if (cnt == ZERO) begin
              cnt_d = sat ? ZERO : MAX_VAL;
              tc_d  = 1'b1;
              ovf_d = 1'b1;
            end else if (cnt > MAX_VAL) begin
              // Out-of-range value left by raw mode re-enters at the top.
              cnt_d = MAX_VAL;
            end else begin
              cnt_d = cnt - ONE;
            end
          end
          MODE_HOLD: begin
            cnt_d = cnt;
          end
        endcase
      end
    endcase
  end

  assign tog = cnt ^ cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk_i  (clk),
      .rst_ni (rst),
      .tog_i  (tog[i]),
      .q_o    (cnt[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = cnt;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_toggle_counter.sv
// Self-checking bench for toggle_counter.
// Two instances (4-bit/MAX 9 and 8-bit default) checked against a model.
module tb_toggle_counter;

  logic       clk = 1'b0;
  logic       rst, en, sat, load;
  logic [1:0] mode;
  logic [3:0] t4, din4, q4;
  logic       tc4, ovf4;
  logic [7:0] t8, din8, q8;
  logic       tc8, ovf8;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  toggle_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat),
    .t(t4), .load(load), .din(din4),
    .q(q4), .tc(tc4), .ovf(ovf4)
  );

  toggle_counter #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sat(sat),
    .t(t8), .load(load), .din(din8),
    .q(q8), .tc(tc8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [31:0] q;
    logic        tc;
    logic        ovf;
  } ms_t;

  ms_t m4 = '0;
  ms_t m8 = '0;

  function automatic ms_t mstep(ms_t s, int unsigned maxv,
                                logic [31:0] mask, logic ld,
                                logic [31:0] d, logic e,
                                logic [1:0] m, logic st,
                                logic [31:0] tm);
    ms_t n = s;
    n.tc = 1'b0;
    if (ld) begin
      n.q = (d > maxv) ? maxv : d;
      n.ovf = 1'b0;
    end else if (e) begin
      case (m)
        2'd0: n.q = (s.q ^ tm) & mask;
        2'd1: begin
          if (s.q < maxv) n.q = s.q + 1;
          else begin
            n.q = st ? maxv : 0;
            n.tc = 1'b1;
            n.ovf = 1'b1;
          end
        end
        2'd2: begin
          if (s.q == 0) begin
            n.q = st ? 0 : maxv;
            n.tc = 1'b1;
            n.ovf = 1'b1;
          end else if (s.q > maxv) n.q = maxv;
          else n.q = s.q - 1;
        end
        default: n.q = s.q;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m4 = '0;
      m8 = '0;
    end else begin
      m4 = mstep(m4, 9, 32'hF, load, 32'(din4), en, mode, sat, 32'(t4));
      m8 = mstep(m8, 255, 32'hFF, load, 32'(din8), en, mode, sat, 32'(t8));
    end
  end

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_q4", 32'(q4), m4.q);
      chk("model_tc4", 32'(tc4), 32'(m4.tc));
      chk("model_ovf4", 32'(ovf4), 32'(m4.ovf));
      chk("model_q8", 32'(q8), m8.q);
      chk("model_tc8", 32'(tc8), 32'(m8.tc));
      chk("model_ovf8", 32'(ovf8), 32'(m8.ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int s33[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int s34q[4] = '{1, 0, 0, 0};
  int s34t[4] = '{0, 0, 1, 1};

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'd0; sat = 1'b0; load = 1'b0;
    t4 = '0; din4 = '0; t8 = '0; din8 = '0;
    #1;
    chk("reset_q4", 32'(q4), 0);
    chk("reset_tc4", 32'(tc4), 0);
    chk("reset_ovf4", 32'(ovf4), 0);
    chk("reset_q8", 32'(q8), 0);
    cmp_on = 1'b1;

    en = 1'b1; mode = 2'd1;
    tick();
    tick();
    chk("held_in_reset_q4", 32'(q4), 0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("up_wrap_q[%0d]", i), 32'(q4), 32'(s33[i]));
      chk($sformatf("up_wrap_tc[%0d]", i), 32'(tc4), 32'(i == 9));
    end
    chk("up_wrap_ovf", 32'(ovf4), 1);

    load = 1'b1; din4 = 4'd2; din8 = 8'd2; mode = 2'd2; sat = 1'b1;
    tick();
    chk("down_load_q", 32'(q4), 2);
    chk("down_load_ovf", 32'(ovf4), 0);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("down_sat_q[%0d]", i), 32'(q4), 32'(s34q[i]));
      chk($sformatf("down_sat_tc[%0d]", i), 32'(tc4), 32'(s34t[i]));
    end
    chk("down_sat_ovf", 32'(ovf4), 1);

    en = 1'b0; load = 1'b1; din4 = 4'd15; din8 = 8'd200; mode = 2'd1;
    tick();
    chk("load_clamp_q4", 32'(q4), 9);
    chk("load_clamp_ovf", 32'(ovf4), 0);
    chk("load_q8", 32'(q8), 200);

    din4 = 4'd0; din8 = 8'd0;
    tick();
    load = 1'b0; en = 1'b1; mode = 2'd0; sat = 1'b0;
    t8 = 8'hA5; t4 = 4'h5;
    tick();
    chk("raw_q8_a", 32'(q8), 32'hA5);
    chk("raw_tc8_a", 32'(tc8), 0);
    chk("raw_q4_a", 32'(q4), 5);
    tick();
    chk("raw_q8_b", 32'(q8), 0);
    chk("raw_tc8_b", 32'(tc8), 0);

    t4 = 4'hF; t8 = 8'h0;
    tick();
    chk("raw_above_max_q4", 32'(q4), 15);
    mode = 2'd2;
    tick();
    chk("down_from_above_q4", 32'(q4), 9);
    chk("down_from_above_tc4", 32'(tc4), 0);

    mode = 2'd1; sat = 1'b1;
    tick();
    chk("up_sat_q4_a", 32'(q4), 9);
    chk("up_sat_tc4_a", 32'(tc4), 1);
    tick();
    chk("up_sat_q4_b", 32'(q4), 9);
    chk("up_sat_tc4_b", 32'(tc4), 1);

    load = 1'b1; din4 = 4'd7; din8 = 8'd7; sat = 1'b0;
    tick();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("en0_hold_q[%0d]", i), 32'(q4), 7);
      chk($sformatf("en0_hold_tc[%0d]", i), 32'(tc4), 0);
    end
    en = 1'b1; mode = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mode_hold_q[%0d]", i), 32'(q4), 7);
    end
    load = 1'b1; din4 = 4'd3; din8 = 8'd3; mode = 2'd1;
    tick();
    chk("load_wins_q4", 32'(q4), 3);

    load = 1'b0; sat = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("pre_reset_q4", 32'(q4), 5);
    chk("pre_reset_ovf4", 32'(ovf4), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_q4", 32'(q4), 0);
    chk("async_rst_tc4", 32'(tc4), 0);
    chk("async_rst_ovf4", 32'(ovf4), 0);
    chk("async_rst_q8", 32'(q8), 0);
    #4 rst = 1'b1;
    tick();
    chk("post_reset_q4", 32'(q4), 1);
    chk("post_reset_tc4", 32'(tc4), 0);

    @(negedge clk);
    #1;
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
